// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - retire-trace FIFO with drop/overwrite overflow policy and saturating event counters
module pipe_trace_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       mode,
    input  logic                       ret_valid,
    input  logic [WIDTH-1:0]           ret_pc,
    input  logic [4:0]                 ret_rd,
    input  logic                       ret_we,
    input  logic [WIDTH-1:0]           ret_data,
    input  logic                       br_taken,
    input  logic                       mem_rd,
    input  logic                       mem_wr,
    output logic                       tr_valid,
    input  logic                       tr_ready,
    output logic [WIDTH-1:0]           tr_pc,
    output logic [WIDTH-1:0]           tr_data,
    output logic [4:0]                 tr_rd,
    output logic                       tr_we,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic [CNT_W-1:0]           cnt_cycle,
    output logic [CNT_W-1:0]           cnt_retire,
    output logic [CNT_W-1:0]           cnt_branch,
    output logic [CNT_W-1:0]           cnt_mem,
    output logic [CNT_W-1:0]           cnt_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 2 * WIDTH + 6;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic [CNT_W-1:0] cnt_cycle_q, cnt_cycle_d, cnt_retire_q, cnt_retire_d;
    logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d, cnt_mem_q, cnt_mem_d;
    logic [CNT_W-1:0] cnt_drop_q, cnt_drop_d;
    logic [EW-1:0]    head;
    logic             push, pop, wr_en, ovw, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        tr_valid = (level_q != '0);
        head     = mem_q[rd_ptr_q];
        push     = en & ret_valid & ~clr;
        pop      = tr_valid & tr_ready & ~clr;
        // When full without a pop, mode decides between discarding and overwriting the oldest slot.
        drop     = push & full_q & ~pop;
        ovw      = drop & mode;
        wr_en    = push & (~full_q | pop | mode);

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {ret_pc, ret_rd, ret_we, ret_data};
        end
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = (pop | ovw) ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push & ~full_q) - LW'(pop & ~(push & full_q));

        cnt_cycle_d  = sat_inc(cnt_cycle_q, en);
        cnt_retire_d = sat_inc(cnt_retire_q, en & ret_valid);
        cnt_branch_d = sat_inc(cnt_branch_q, en & br_taken);
        cnt_mem_d    = sat_inc(cnt_mem_q, en & (mem_rd | mem_wr));
        cnt_drop_d   = sat_inc(cnt_drop_q, drop);

        if (clr) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            cnt_cycle_d  = '0;
            cnt_retire_d = '0;
            cnt_branch_d = '0;
            cnt_mem_d    = '0;
            cnt_drop_d   = '0;
        end
        full_d = (level_d == LW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            full_q       <= 1'b0;
            cnt_cycle_q  <= '0;
            cnt_retire_q <= '0;
            cnt_branch_q <= '0;
            cnt_mem_q    <= '0;
            cnt_drop_q   <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            full_q       <= full_d;
            cnt_cycle_q  <= cnt_cycle_d;
            cnt_retire_q <= cnt_retire_d;
            cnt_branch_q <= cnt_branch_d;
            cnt_mem_q    <= cnt_mem_d;
            cnt_drop_q   <= cnt_drop_d;
        end
    end

    assign tr_pc      = tr_valid ? head[EW-1 -: WIDTH]     : '0;
    assign tr_rd      = tr_valid ? head[WIDTH+5:WIDTH+1]   : '0;
    assign tr_we      = tr_valid ? head[WIDTH]             : 1'b0;
    assign tr_data    = tr_valid ? head[WIDTH-1:0]         : '0;
    assign level      = level_q;
    assign full       = full_q;
    assign cnt_cycle  = cnt_cycle_q;
    assign cnt_retire = cnt_retire_q;
    assign cnt_branch = cnt_branch_q;
    assign cnt_mem    = cnt_mem_q;
    assign cnt_drop   = cnt_drop_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - directed self-checking bench for pipe_trace_buffer
module tb_pipe_trace_buffer;
    logic        clk = 1'b0;
    logic        rst_n, en, clr, mode, ret_valid, ret_we, br_taken, mem_rd, mem_wr, tr_ready;
    logic [31:0] ret_pc, ret_data;
    logic [4:0]  ret_rd;
    logic        tr_valid, tr_we, full;
    logic [31:0] tr_pc, tr_data;
    logic [4:0]  tr_rd;
    logic [2:0]  level;
    logic [31:0] cnt_cycle, cnt_retire, cnt_branch, cnt_mem, cnt_drop;

    logic        s_tr_valid, s_tr_we, s_full;
    logic [31:0] s_tr_pc, s_tr_data;
    logic [4:0]  s_tr_rd;
    logic [1:0]  s_level;
    logic [3:0]  s_cnt_cycle, s_cnt_retire, s_cnt_branch, s_cnt_mem, s_cnt_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_trace_buffer #(.WIDTH(32), .DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_rd(ret_rd), .ret_we(ret_we), .ret_data(ret_data),
        .br_taken(br_taken), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_data(tr_data),
        .tr_rd(tr_rd), .tr_we(tr_we), .level(level), .full(full),
        .cnt_cycle(cnt_cycle), .cnt_retire(cnt_retire), .cnt_branch(cnt_branch),
        .cnt_mem(cnt_mem), .cnt_drop(cnt_drop)
    );

    pipe_trace_buffer #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_rd(ret_rd), .ret_we(ret_we), .ret_data(ret_data),
        .br_taken(br_taken), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .tr_valid(s_tr_valid), .tr_ready(tr_ready), .tr_pc(s_tr_pc), .tr_data(s_tr_data),
        .tr_rd(s_tr_rd), .tr_we(s_tr_we), .level(s_level), .full(s_full),
        .cnt_cycle(s_cnt_cycle), .cnt_retire(s_cnt_retire), .cnt_branch(s_cnt_branch),
        .cnt_mem(s_cnt_mem), .cnt_drop(s_cnt_drop)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            ret_valid = 1'b1;
            ret_pc    = base + 32'(i * 4);
            ret_rd    = 5'(i + 1);
            ret_we    = 1'b1;
            ret_data  = 32'h100 + 32'(i);
            step();
        end
        ret_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; mode = 1'b0; ret_valid = 1'b0; ret_pc = '0;
        ret_rd = '0; ret_we = 1'b0; ret_data = '0; br_taken = 1'b0; mem_rd = 1'b0;
        mem_wr = 1'b0; tr_ready = 1'b0;
        step();
        step();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (tr_valid !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got v=%b f=%b exp 0 0", tr_valid, full); end
        checks++; if (tr_pc !== 32'd0 || cnt_cycle !== 32'd0) begin errors++; $display("FAIL reset_zero got pc=%h cyc=%0d exp 0 0", tr_pc, cnt_cycle); end
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        do_clr();
        push_n(3, 32'h0);
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL basic_level got %0d exp 3", level); end
        checks++; if (tr_valid !== 1'b1 || tr_pc !== 32'h0 || tr_rd !== 5'd1 || tr_data !== 32'h100 || tr_we !== 1'b1)
            begin errors++; $display("FAIL basic_head got v=%b pc=%h rd=%0d d=%h we=%b exp 1 0 1 100 1", tr_valid, tr_pc, tr_rd, tr_data, tr_we); end
        tr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (tr_valid !== 1'b1 || tr_pc !== 32'(i * 4)) begin errors++; $display("FAIL basic_drain%0d got v=%b pc=%h exp 1 %h", i, tr_valid, tr_pc, i * 4); end
            step();
        end
        checks++; if (tr_valid !== 1'b0 || level !== 3'd0 || tr_pc !== 32'd0) begin errors++; $display("FAIL basic_empty got v=%b l=%0d pc=%h exp 0 0 0", tr_valid, level, tr_pc); end
        step();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL empty_pop got %0d exp 0", level); end
        tr_ready = 1'b0;
    endtask

    task automatic test_drop();
        do_clr();
        mode = 1'b0;
        push_n(6, 32'h0);
        checks++; if (level !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL drop_level got l=%0d f=%b exp 4 1", level, full); end
        checks++; if (cnt_drop !== 32'd2 || cnt_retire !== 32'd6) begin errors++; $display("FAIL drop_cnt got d=%0d r=%0d exp 2 6", cnt_drop, cnt_retire); end
        tr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (tr_pc !== 32'(i * 4)) begin errors++; $display("FAIL drop_drain%0d got %h exp %h", i, tr_pc, i * 4); end
            step();
        end
        checks++; if (tr_valid !== 1'b0) begin errors++; $display("FAIL drop_empty got %b exp 0", tr_valid); end
        tr_ready = 1'b0;
    endtask

    task automatic test_overwrite();
        do_clr();
        mode = 1'b1;
        push_n(6, 32'h0);
        checks++; if (level !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL ovw_level got l=%0d f=%b exp 4 1", level, full); end
        checks++; if (cnt_drop !== 32'd2 || cnt_retire !== 32'd6) begin errors++; $display("FAIL ovw_cnt got d=%0d r=%0d exp 2 6", cnt_drop, cnt_retire); end
        tr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (tr_pc !== 32'(8 + i * 4)) begin errors++; $display("FAIL ovw_drain%0d got %h exp %h", i, tr_pc, 8 + i * 4); end
            step();
        end
        checks++; if (tr_valid !== 1'b0) begin errors++; $display("FAIL ovw_empty got %b exp 0", tr_valid); end
        tr_ready = 1'b0;
        mode = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_clr();
        mode = 1'b0;
        push_n(4, 32'h0);
        tr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1'b1;
            ret_pc    = 32'h10 + 32'(i * 4);
            checks++; if (tr_pc !== 32'(i * 4)) begin errors++; $display("FAIL bb_head%0d got %h exp %h", i, tr_pc, i * 4); end
            step();
            checks++; if (level !== 3'd4) begin errors++; $display("FAIL bb_level%0d got %0d exp 4", i, level); end
        end
        ret_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (tr_pc !== 32'(16 + i * 4)) begin errors++; $display("FAIL bb_wrap%0d got %h exp %h", i, tr_pc, 16 + i * 4); end
            step();
        end
        checks++; if (cnt_drop !== 32'd0 || tr_valid !== 1'b0) begin errors++; $display("FAIL bb_nodrop got d=%0d v=%b exp 0 0", cnt_drop, tr_valid); end
        tr_ready = 1'b0;
    endtask

    task automatic test_counters();
        logic [9:0] br_pat, rd_pat, wr_pat;
        br_pat = 10'b0010001001;
        rd_pat = 10'b0100100010;
        wr_pat = 10'b0000100100;
        do_clr();
        for (int i = 0; i < 10; i++) begin
            br_taken = br_pat[i];
            mem_rd   = rd_pat[i];
            mem_wr   = wr_pat[i];
            step();
        end
        en = 1'b0; br_taken = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        checks++; if (cnt_cycle !== 32'd10) begin errors++; $display("FAIL cnt_cycle got %0d exp 10", cnt_cycle); end
        checks++; if (cnt_branch !== 32'd3 || cnt_mem !== 32'd4) begin errors++; $display("FAIL cnt_ev got b=%0d m=%0d exp 3 4", cnt_branch, cnt_mem); end
        br_taken = 1'b1;
        step();
        step();
        br_taken = 1'b0;
        checks++; if (cnt_cycle !== 32'd10 || cnt_branch !== 32'd3) begin errors++; $display("FAIL cnt_en0 got c=%0d b=%0d exp 10 3", cnt_cycle, cnt_branch); end
        en = 1'b1;
        do_clr();
        for (int i = 0; i < 20; i++) step();
        checks++; if (s_cnt_cycle !== 4'd15) begin errors++; $display("FAIL cnt_sat got %0d exp 15", s_cnt_cycle); end
        checks++; if (cnt_cycle !== 32'd20) begin errors++; $display("FAIL cnt_nosat got %0d exp 20", cnt_cycle); end
    endtask

    task automatic test_clr();
        do_clr();
        push_n(1, 32'h40);
        ret_valid = 1'b1; ret_pc = 32'h44; clr = 1'b1;
        step();
        clr = 1'b0; ret_valid = 1'b0;
        checks++; if (level !== 3'd0 || tr_valid !== 1'b0) begin errors++; $display("FAIL clr_fifo got l=%0d v=%b exp 0 0", level, tr_valid); end
        checks++; if (cnt_cycle !== 32'd0 || cnt_retire !== 32'd0) begin errors++; $display("FAIL clr_cnt got c=%0d r=%0d exp 0 0", cnt_cycle, cnt_retire); end
        step();
        checks++; if (level !== 3'd0 || cnt_cycle !== 32'd1) begin errors++; $display("FAIL clr_after got l=%0d c=%0d exp 0 1", level, cnt_cycle); end
    endtask

    task automatic test_async_reset();
        push_n(2, 32'h80);
        checks++; if (level !== 3'd2 || tr_pc !== 32'h80) begin errors++; $display("FAIL ar_pre got l=%0d pc=%h exp 2 80", level, tr_pc); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tr_valid !== 1'b0 || level !== 3'd0 || tr_pc !== 32'd0) begin errors++; $display("FAIL ar_async got v=%b l=%0d pc=%h exp 0 0 0", tr_valid, level, tr_pc); end
        rst_n = 1'b1;
        step();
        checks++; if (level !== 3'd0 || cnt_cycle !== 32'd1) begin errors++; $display("FAIL ar_release got l=%0d c=%0d exp 0 1", level, cnt_cycle); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_overwrite();
        test_full_push_pop();
        test_counters();
        test_clr();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
